mem_responder: RTL and testbench

Memory-side responder for the multicycle core's instruction/data memory port. It accepts one request at a time from the core's memory interface: a word read (instruction fetch or load) or a byte-strobed write (store). It services the request from an internal word array after a fixed, parameterised latency and returns a response through a valid/ready handshake. It replaces the zero-wait combinational memory, so the controller FSM can be tested against realistic wait states.

---
 rtl/mem_responder_pkg.sv | 6 +
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder_word_array.sv | 26 ++
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_resp_pkg: shared state encoding and address/strobe constants for the memory responder
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
    localparam int WORD_SHIFT = 2;
    localparam int STRB_W = 4;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response handshake between the core memory port and the responder
interface mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder_word_array.sv
// mem_word_array: word array with byte-strobed synchronous write and synchronous read
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [31:0]       wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < STRB_W; i++)
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (en && !we) rdata_q <= mem[idx];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency and error checking
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = LATENCY > 2 ? $clog2(LATENCY - 1) : 1;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d, err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              accept, commit, req_err;
    logic              a_we, a_err;
    logic [IDX_W-1:0]  a_idx;
    logic [31:0]       a_wdata, arr_rdata;
    logic [STRB_W-1:0] a_wstrb;
    assign accept  = bus.req_valid && state_q == IDLE;
    assign req_err = |bus.req_addr[WORD_SHIFT-1:0] ||
                     (bus.req_addr >> WORD_SHIFT) >= ADDR_W'(DEPTH_WORDS);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (accept) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
            we_d    = bus.req_we;
            err_d   = req_err;
            idx_d   = bus.req_addr[WORD_SHIFT +: IDX_W];
            wdata_d = bus.req_wdata;
            wstrb_d = bus.req_wstrb;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == '0 ? RESP : WAIT;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end else if (state_q == RESP && bus.resp_ready) begin
            state_d = IDLE;
        end
    end
    // With LATENCY=1 the array is accessed on the accept edge, so take the live request
    always_comb begin
        a_we    = state_q == IDLE ? bus.req_we : we_q;
        a_err   = state_q == IDLE ? req_err : err_q;
        a_idx   = state_q == IDLE ? bus.req_addr[WORD_SHIFT +: IDX_W] : idx_q;
        a_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
        a_wstrb = state_q == IDLE ? bus.req_wstrb : wstrb_q;
        commit  = !rst && (accept ? LATENCY == 1 : state_q == WAIT && cnt_q == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end
    mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .en    (commit && !a_err),
        .we    (a_we),
        .idx   (a_idx),
        .wdata (a_wdata),
        .wstrb (a_wstrb),
        .rdata (arr_rdata)
    );
    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_err   = state_q == RESP && err_q;
    assign bus.resp_rdata = state_q == RESP && !we_q && !err_q ? arr_rdata : 32'd0;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed checks of two responders (LATENCY 2 and 1) against an array model
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        busy0, busy1;
    int          n_checks = 0, n_errors = 0;
    logic [31:0] ref_mem [2][1024];
    always #5 clk = ~clk;
    mem_responder_if #(.ADDR_W(32)) bus0 ();
    mem_responder_if #(.ADDR_W(32)) bus1 ();
    assign bus0.req_valid  = req_valid && !sel;
    assign bus1.req_valid  = req_valid && sel;
    assign bus0.resp_ready = resp_ready && !sel;
    assign bus1.resp_ready = resp_ready && sel;
    assign bus0.req_we = req_we;       assign bus1.req_we = req_we;
    assign bus0.req_addr = req_addr;   assign bus1.req_addr = req_addr;
    assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata;
    assign bus0.req_wstrb = req_wstrb; assign bus1.req_wstrb = req_wstrb;
    wire        o_req_ready  = sel ? bus1.req_ready  : bus0.req_ready;
    wire        o_resp_valid = sel ? bus1.resp_valid : bus0.resp_valid;
    wire [31:0] o_rdata      = sel ? bus1.resp_rdata : bus0.resp_rdata;
    wire        o_err        = sel ? bus1.resp_err   : bus0.resp_err;
    wire        o_busy       = sel ? busy1 : busy0;
    mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
    mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut%0d): got %h expected %h", tag, sel, got, exp);
        end
    endtask
    function automatic logic addr_err(input logic [31:0] a);
        return a[1:0] != 2'd0 || a[31:2] >= 30'd1024;
    endfunction
    task automatic wait_idle();
        for (int k = 0; k < 20 && !o_req_ready; k++) begin
            @(posedge clk); #1;
        end
        check("idle_ready", o_req_ready, 1);
    endtask
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!addr_err(a))
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[sel][a[11:2]][8*i +: 8] = d[8*i +: 8];
    endtask
    task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, input bit pulse);
        int lat;
        logic exp_err;
        logic [31:0] exp_rd, held;
        wait_idle();
        exp_err = addr_err(a);
        exp_rd  = (exp_err || we) ? 32'd0 : ref_mem[sel][a[11:2]];
        if (we) model_write(a, d, s);
        drive_req(we, a, d, s);
        lat = 1;
        while (!o_resp_valid && lat < 20) begin
            if (pulse) begin
                req_valid = 1'b1; req_addr = a ^ 32'h4; req_we = !we;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end
        check("latency", lat, sel ? 1 : 2);
        if (!o_resp_valid) return;
        check("rdata", o_rdata, exp_rd);
        check("err", o_err, exp_err);
        check("ready_in_resp", o_req_ready, 0);
        held = o_rdata;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", o_resp_valid, 1);
            check("hold_rdata", o_rdata, held);
            check("hold_ready", o_req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("exit_valid", o_resp_valid, 0);
        check("exit_busy", o_busy, 0);
    endtask
    task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        if (sel) model_write(a, d, 4'hF);
        drive_req(1'b1, a, d, 4'hF);
        check("mid_busy", o_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_resp_valid, 0);
        check("rst_ready", o_req_ready, 1);
    endtask
    initial begin
        logic [31:0] a;
        int r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            check("rst_req_ready", o_req_ready, 1);
            check("rst_resp_valid", o_resp_valid, 0);
            check("rst_busy", o_busy, 0);
            check("rst_rdata", o_rdata, 0);
            check("rst_err", o_err, 0);
            repeat (4) begin
                resp_ready = !resp_ready;
                @(posedge clk); #1;
                check("idle_toggle_valid", o_resp_valid, 0);
                check("idle_toggle_busy", o_busy, 0);
            end
            resp_ready = 1'b0;
            for (int w = 0; w < 64; w++) txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);
        end
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
            txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
            txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
            txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
            txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
            check("strobe_model", ref_mem[sel][8], 32'h11BB33DD);
            txn(1'b1, 32'h24, 32'h12345678, 4'h0, 0, 1'b0);
            txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0);
            txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
            txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
            txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
            txn(1'b1, 32'h40, 32'h0, 4'hF, 0, 1'b0);
            reset_mid(32'h40, 32'h55555555);
            txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);
        end
        repeat (300) begin
            sel = bit'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            a = r == 0 ? (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3)) :
                r == 1 ? 32'($urandom_range(1024, 4095)) << 2 :
                         32'($urandom_range(0, 63)) << 2;
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
